// File: rtl/serial_pkg.sv
// Shared definitions for the serial code path: FSM state encoding, the
// default idle line level and a small width helper. The downstream pattern
// detector imports this package as well.
package serial_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'b00;
   localparam state_t SHIFT = 2'b01;
   localparam state_t GAP   = 2'b10;

   localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int count_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_counter.sv
// Bit index and inter-word gap counters for code_serializer. Both counters
// saturate at their terminal value; the FSM restarts them with a load.
module shift_counter
   import serial_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic bit_load,
   input  logic bit_inc,
   input  logic gap_load,
   input  logic gap_inc,
   output logic bit_last,
   output logic bit_penult,
   output logic gap_last
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_PENULT = BW'(WIDTH - 2);

   logic [BW-1:0] bit_cnt_reg;

   // Index of the bit currently on the line; restarts at 0 on each word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         bit_cnt_reg <= '0;
      else if (bit_load)
         bit_cnt_reg <= '0;
      else if (bit_inc && (bit_cnt_reg != BIT_LAST))
         bit_cnt_reg <= bit_cnt_reg + 1'b1;
   end

   assign bit_last   = (bit_cnt_reg == BIT_LAST);
   assign bit_penult = (bit_cnt_reg == BIT_PENULT);

   generate
      if (GAP_CYCLES > 0) begin : g_gap
         localparam int GW = count_width(GAP_CYCLES);
         localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

         logic [GW-1:0] gap_cnt_reg;

         // Counts idle cycles after a word; terminal value is the final gap cycle.
         always_ff @(posedge clock or posedge reset) begin
            if (reset)
               gap_cnt_reg <= '0;
            else if (gap_load)
               gap_cnt_reg <= '0;
            else if (gap_inc && (gap_cnt_reg != GAP_LAST))
               gap_cnt_reg <= gap_cnt_reg + 1'b1;
         end

         assign gap_last = (gap_cnt_reg == GAP_LAST);
      end else begin : g_no_gap
         logic unused_gap_ctrl;
         assign unused_gap_ctrl = gap_load ^ gap_inc;
         assign gap_last        = 1'b1;
      end
   endgenerate

endmodule

// File: rtl/code_serializer.sv
// Parallel-to-serial front end for the "01" pattern detector. Accepts a word
// over valid/ready, drives it one bit per clock on a registered code line and
// holds the line at IDLE_LEVEL between words, with an optional forced gap.
module code_serializer
   import serial_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
   parameter int   GAP_CYCLES = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid,
   output logic             ready,
   output logic             code,
   output logic             busy,
   output logic             done
);

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] shreg_next;
   logic             code_reg;
   logic             code_next;
   logic             done_reg;
   logic             done_next;

   logic             accept;
   logic             bit_load;
   logic             bit_inc;
   logic             gap_load;
   logic             gap_inc;
   logic             bit_last;
   logic             bit_penult;
   logic             gap_last;

   shift_counter #(
      .WIDTH      (WIDTH),
      .GAP_CYCLES (GAP_CYCLES)
   ) u_shift_counter (
      .clock      (clock),
      .reset      (reset),
      .bit_load   (bit_load),
      .bit_inc    (bit_inc),
      .gap_load   (gap_load),
      .gap_inc    (gap_inc),
      .bit_last   (bit_last),
      .bit_penult (bit_penult),
      .gap_last   (gap_last)
   );

   // State register; reset drops any partial word immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic: a word may start from IDLE, from the last bit when no
   // gap is configured, or from the final gap cycle.
   always_comb begin
      state_next = IDLE;
      case (state_reg)
         IDLE:  state_next = accept ? SHIFT : IDLE;
         SHIFT: begin
            if (!bit_last)
               state_next = SHIFT;
            else if (GAP_CYCLES > 0)
               state_next = GAP;
            else
               state_next = accept ? SHIFT : IDLE;
         end
         GAP: begin
            if (!gap_last)
               state_next = GAP;
            else
               state_next = accept ? SHIFT : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output and datapath decode from registered state only, so ready never
   // depends on valid; the next code bit and done pulse are prepared here.
   always_comb begin
      ready      = 1'b0;
      busy       = (state_reg != IDLE);
      shreg_next = shreg_reg;
      code_next  = IDLE_LEVEL;
      done_next  = 1'b0;

      case (state_reg)
         IDLE:    ready = 1'b1;
         SHIFT:   ready = bit_last && (GAP_CYCLES == 0);
         GAP:     ready = gap_last;
         default: ready = 1'b0;
      endcase

      accept   = valid && ready;
      bit_load = accept;
      bit_inc  = (state_reg == SHIFT) && !bit_last;
      gap_load = (state_reg == SHIFT) && bit_last;
      gap_inc  = (state_reg == GAP);

      if (accept) begin
         if (MSB_FIRST) begin
            code_next  = data_in[WIDTH-1];
            shreg_next = data_in << 1;
         end else begin
            code_next  = data_in[0];
            shreg_next = data_in >> 1;
         end
      end else if ((state_reg == SHIFT) && !bit_last) begin
         if (MSB_FIRST) begin
            code_next  = shreg_reg[WIDTH-1];
            shreg_next = shreg_reg << 1;
         end else begin
            code_next  = shreg_reg[0];
            shreg_next = shreg_reg >> 1;
         end
         done_next = bit_penult;
      end
   end

   // Registered line, done pulse and remaining-bits shift register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg_reg <= '0;
         code_reg  <= IDLE_LEVEL;
         done_reg  <= 1'b0;
      end else begin
         shreg_reg <= shreg_next;
         code_reg  <= code_next;
         done_reg  <= done_next;
      end
   end

   assign code = code_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: three configurations share clock and reset.
//   u0: MSB first, idle 1, no gap   u1: LSB first, idle 0, no gap
//   u2: MSB first, idle 0, 3-cycle gap
// Expected line activity comes from a timeline model: a word accepted in
// cycle a occupies cycles a+1..a+W, done in a+W, busy through a+W+GAP, and
// the next word may be accepted from cycle a+W+GAP on.
module tb_code_serializer;

   localparam int W  = 8;
   localparam int NI = 3;

   typedef struct {
      int         a;
      logic [W-1:0] w;
   } xfer_t;

   logic          clock = 1'b0;
   logic          reset;
   logic [NI-1:0] valid_v;
   logic [W-1:0]  data_v [NI];
   logic [NI-1:0] ready_v;
   logic [NI-1:0] code_v;
   logic [NI-1:0] busy_v;
   logic [NI-1:0] done_v;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   code_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) u0 (
      .clock(clock), .reset(reset), .data_in(data_v[0]), .valid(valid_v[0]),
      .ready(ready_v[0]), .code(code_v[0]), .busy(busy_v[0]), .done(done_v[0]));

   code_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) u1 (
      .clock(clock), .reset(reset), .data_in(data_v[1]), .valid(valid_v[1]),
      .ready(ready_v[1]), .code(code_v[1]), .busy(busy_v[1]), .done(done_v[1]));

   code_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(3)) u2 (
      .clock(clock), .reset(reset), .data_in(data_v[2]), .valid(valid_v[2]),
      .ready(ready_v[2]), .code(code_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   function automatic bit msb_of(input int s);
      return s != 1;
   endfunction

   function automatic logic idle_of(input int s);
      return (s == 0) ? 1'b1 : 1'b0;
   endfunction

   function automatic int gap_of(input int s);
      return (s == 2) ? 3 : 0;
   endfunction

   // Drives a word list into instance s (word k offered delays[k] cycles after
   // the previous accept) and checks every output on every cycle.
   task automatic run_stream(input int s, input string tag,
                             input logic [W-1:0] words[$], input int delays[$]);
      xfer_t acc[$];
      int    c        = 0;
      int    k        = 0;
      int    earliest = 0;
      int    last_end = 0;
      int    offer;
      int    n;
      int    i;
      logic  exp_code;
      logic  exp_done;
      logic  exp_busy;
      logic  exp_ready;
      n     = words.size();
      offer = delays[0];
      forever begin
         exp_code = idle_of(s);
         exp_done = 1'b0;
         exp_busy = 1'b0;
         foreach (acc[j]) begin
            if (c >= acc[j].a + 1 && c <= acc[j].a + W) begin
               i        = c - acc[j].a - 1;
               exp_code = msb_of(s) ? acc[j].w[W-1-i] : acc[j].w[i];
            end
            if (c == acc[j].a + W)
               exp_done = 1'b1;
            if (c >= acc[j].a + 1 && c <= acc[j].a + W + gap_of(s))
               exp_busy = 1'b1;
         end
         exp_ready = (c >= earliest);

         vectors++;
         if (code_v[s] !== exp_code) begin
            miscompares++;
            $display("FAIL %s u%0d cycle %0d code got %b exp %b", tag, s, c, code_v[s], exp_code);
         end
         vectors++;
         if (done_v[s] !== exp_done) begin
            miscompares++;
            $display("FAIL %s u%0d cycle %0d done got %b exp %b", tag, s, c, done_v[s], exp_done);
         end
         vectors++;
         if (busy_v[s] !== exp_busy) begin
            miscompares++;
            $display("FAIL %s u%0d cycle %0d busy got %b exp %b", tag, s, c, busy_v[s], exp_busy);
         end
         vectors++;
         if (ready_v[s] !== exp_ready) begin
            miscompares++;
            $display("FAIL %s u%0d cycle %0d ready got %b exp %b", tag, s, c, ready_v[s], exp_ready);
         end

         if (k == n && c >= last_end + 2)
            break;
         if (c > 3000) begin
            miscompares++;
            $display("FAIL %s u%0d stream timeout at cycle %0d", tag, s, c);
            break;
         end

         if (k < n && c >= offer) begin
            valid_v[s] = 1'b1;
            data_v[s]  = words[k];
            if (exp_ready) begin
               acc.push_back('{c, words[k]});
               earliest = c + W + gap_of(s);
               last_end = earliest;
               k++;
               if (k < n)
                  offer = c + 1 + delays[k];
            end
         end else begin
            valid_v[s] = 1'b0;
            data_v[s]  = W'($urandom);
         end
         @(negedge clock);
         c++;
      end
      valid_v[s] = 1'b0;
      $display("stream %s u%0d: %0d words in %0d cycles", tag, s, n, c);
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      valid_v = '0;
      for (int s = 0; s < NI; s++)
         data_v[s] = '0;
      repeat (2) @(negedge clock);
      for (int s = 0; s < NI; s++) begin
         vectors++;
         if (code_v[s] !== idle_of(s) || busy_v[s] !== 1'b0 ||
             ready_v[s] !== 1'b1 || done_v[s] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset u%0d code/busy/ready/done got %b%b%b%b exp %b010",
                     s, code_v[s], busy_v[s], ready_v[s], done_v[s], idle_of(s));
         end
      end
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (busy_v !== '0 || ready_v !== '1 || done_v !== '0) begin
         miscompares++;
         $display("FAIL reset_release busy %b ready %b done %b exp 000 111 000", busy_v, ready_v, done_v);
      end
   endtask

   task automatic test_single_word();
      logic [W-1:0] w[$];
      int           d[$];
      w.push_back(8'hA5); d.push_back(0);
      run_stream(0, "single_a5", w, d);
   endtask

   task automatic test_lsb_first();
      logic [W-1:0] w[$];
      int           d[$];
      w.push_back(8'h01); d.push_back(2);
      run_stream(1, "lsb_01", w, d);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w[$];
      int           d[$];
      w.push_back(8'hF0); d.push_back(0);
      w.push_back(8'h0F); d.push_back(0);
      run_stream(0, "b2b_msb", w, d);
      run_stream(1, "b2b_lsb", w, d);
   endtask

   task automatic test_gap();
      logic [W-1:0] w[$];
      int           d[$];
      w.push_back(8'hC3); d.push_back(0);
      w.push_back(8'h5A); d.push_back(0);
      w.push_back(8'hFF); d.push_back(9);
      run_stream(2, "gap3", w, d);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] w[$];
      int           d[$];
      w.push_back(8'hA5); d.push_back(1);
      w.push_back(8'h3C); d.push_back(3);
      w.push_back(8'h81); d.push_back(6);
      run_stream(0, "bp_u0", w, d);
      run_stream(2, "bp_u2", w, d);
   endtask

   task automatic test_random();
      logic [W-1:0] w[$];
      int           d[$];
      for (int s = 0; s < NI; s++) begin
         w.delete();
         d.delete();
         for (int k = 0; k < 15; k++) begin
            w.push_back(W'($urandom));
            d.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 12)));
         end
         run_stream(s, "random", w, d);
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] w[$];
      int           d[$];
      valid_v[2] = 1'b1;
      data_v[2]  = 8'h55;
      @(negedge clock);
      valid_v[2] = 1'b0;
      repeat (3) @(negedge clock);
      vectors++;
      if (code_v[2] !== 1'b1 || busy_v[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_bit4 code/busy got %b%b exp 11", code_v[2], busy_v[2]);
      end
      #1 reset = 1'b1;
      #1;
      vectors++;
      if (code_v[2] !== 1'b0 || busy_v[2] !== 1'b0 || ready_v[2] !== 1'b1 || done_v[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset code/busy/ready/done got %b%b%b%b exp 0010",
                  code_v[2], busy_v[2], ready_v[2], done_v[2]);
      end
      #1 reset = 1'b0;
      @(negedge clock);
      w.push_back(8'h96); d.push_back(0);
      run_stream(2, "post_reset", w, d);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_word();
      test_lsb_first();
      test_back_to_back();
      test_gap();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
